ram_writer: RTL and testbench

Accepts an AXI-Stream of data and writes it to RAM through an AXI4 memory-mapped master, starting at address 0. The transfer is a run of full fixed-size bursts, optionally followed by one shorter partial burst. The block finishes when every write response has returned. It is the fill side of the RAM buffer path, feeding the stream-out reader that drains the same RAM.

---
 rtl/ram_writer.sv | 248 ++++++++++++++++++++++++
 tb/tb_ram_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_writer: AXI-Stream in, AXI4 write master out. Writes full bursts from  |
// | address 0, then an optional partial burst, and waits for every response.   |
// | Optional debug ports: define RAM_WRITER_DEBUG_EN.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ram_writer #(
  parameter int DW               = 512,
  parameter int IW               = 4,
  parameter int CYCLES_PER_BLOCK = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       full_blocks,
  input  logic [7:0]        partial_block_cycles,
  input  logic              start,
  output logic              idle,
  output logic              bresp_error,
`ifdef RAM_WRITER_DEBUG_EN
  output logic [1:0]        dbg_fsm_state,
  output logic [31:0]       dbg_beats_written,
  output logic [31:0]       dbg_bursts_acked,
`endif
  input  logic [DW-1:0]     AXIS_IN_TDATA,
  input  logic              AXIS_IN_TVALID,
  output logic              AXIS_IN_TREADY,
  output logic [63:0]       M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic [IW-1:0]     M_AXI_AWID,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [3:0]        M_AXI_AWQOS,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DW-1:0]     M_AXI_WDATA,
  output logic [DW/8-1:0]   M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  output logic              M_AXI_WLAST,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [63:0]       M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic [IW-1:0]     M_AXI_ARID,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [3:0]        M_AXI_ARQOS,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DW-1:0]     M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic [IW-1:0]     M_AXI_RID,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam logic [63:0] BURST_BYTES = 64'(CYCLES_PER_BLOCK * DW / 8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FULL    = 2'd1,
    S_PARTIAL = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_awvalid;
  logic [63:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic [31:0] r_nblk;
  logic [7:0]  r_npart;
  logic [32:0] r_total;
  logic [31:0] r_aw_blocks;
  logic        r_w_active;
  logic [7:0]  r_beat;
  logic [32:0] r_w_bursts;
  logic [32:0] r_b_count;
  logic        r_bresp_error;

  logic        w_start_acc;
  logic [32:0] w_start_total;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic [8:0]  w_len;
  logic        w_last;
  logic        w_unused;

  assign w_start_acc   = start && (r_state == S_IDLE);
  assign w_start_total = {1'b0, full_blocks} + {32'd0, (partial_block_cycles != 8'd0)};
  assign w_aw_hs       = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs        = AXIS_IN_TVALID && M_AXI_WREADY && r_w_active;
  // Full-length bursts come first, so the burst index alone selects the length.
  assign w_len         = (r_w_bursts < {1'b0, r_nblk}) ? 9'(CYCLES_PER_BLOCK) : {1'b0, r_npart};
  assign w_last        = r_w_active && ({1'b0, r_beat} == (w_len - 9'd1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_awaddr    <= 64'd0;
      r_awlen     <= 8'd0;
      r_nblk      <= 32'd0;
      r_npart     <= 8'd0;
      r_total     <= 33'd0;
      r_aw_blocks <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nblk      <= full_blocks;
            r_npart     <= partial_block_cycles;
            r_total     <= w_start_total;
            r_aw_blocks <= 32'd0;
            r_awaddr    <= 64'd0;
            if (full_blocks != 32'd0) begin
              r_state   <= S_FULL;
              r_awvalid <= 1'b1;
              r_awlen   <= 8'(CYCLES_PER_BLOCK - 1);
            end else if (partial_block_cycles != 8'd0) begin
              r_state   <= S_PARTIAL;
              r_awvalid <= 1'b1;
              r_awlen   <= partial_block_cycles - 8'd1;
            end
          end
        end
        S_FULL: begin
          if (w_aw_hs) begin
            r_awaddr    <= r_awaddr + BURST_BYTES;
            r_aw_blocks <= r_aw_blocks + 32'd1;
            if (({1'b0, r_aw_blocks} + 33'd1) >= {1'b0, r_nblk}) begin
              if (r_npart != 8'd0) begin
                r_state <= S_PARTIAL;
                r_awlen <= r_npart - 8'd1;
              end else begin
                r_state   <= S_WAIT;
                r_awvalid <= 1'b0;
              end
            end
          end
        end
        S_PARTIAL: begin
          if (w_aw_hs) begin
            r_state   <= S_WAIT;
            r_awvalid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_b_count == r_total) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_awvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_w_active    <= 1'b0;
      r_beat        <= 8'd0;
      r_w_bursts    <= 33'd0;
      r_b_count     <= 33'd0;
      r_bresp_error <= 1'b0;
    end else if (w_start_acc) begin
      r_w_active    <= (w_start_total != 33'd0);
      r_beat        <= 8'd0;
      r_w_bursts    <= 33'd0;
      r_b_count     <= 33'd0;
      r_bresp_error <= 1'b0;
    end else begin
      if (w_w_hs) begin
        if (w_last) begin
          r_beat     <= 8'd0;
          r_w_bursts <= r_w_bursts + 33'd1;
          if ((r_w_bursts + 33'd1) == r_total) r_w_active <= 1'b0;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
      if (M_AXI_BVALID) begin
        r_b_count <= r_b_count + 33'd1;
        if (M_AXI_BRESP != 2'd0) r_bresp_error <= 1'b1;
      end
    end
  end

`ifdef RAM_WRITER_DEBUG_EN
  logic [31:0] r_beats_written;

  always_ff @(posedge clk) begin
    if (!resetn)          r_beats_written <= 32'd0;
    else if (w_start_acc) r_beats_written <= 32'd0;
    else if (w_w_hs)      r_beats_written <= r_beats_written + 32'd1;
  end

  assign dbg_fsm_state     = r_state;
  assign dbg_beats_written = r_beats_written;
  assign dbg_bursts_acked  = r_b_count[31:0];
`endif

  assign idle           = (r_state == S_IDLE) && !start;
  assign bresp_error    = r_bresp_error;
  assign AXIS_IN_TREADY = M_AXI_WREADY && r_w_active;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWVALID = r_awvalid;

  assign M_AXI_WDATA  = AXIS_IN_TDATA;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WVALID = AXIS_IN_TVALID && r_w_active;
  assign M_AXI_WLAST  = w_last;
  assign M_AXI_BREADY = 1'b1;

  // Read side belongs to the stream-out reader; this block never reads.
  assign M_AXI_ARADDR  = 64'd0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'd0;
  assign M_AXI_ARBURST = 2'd0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  assign w_unused = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RID, M_AXI_RVALID};

endmodule
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_writer: directed scenarios against a small AXI slave/stream model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ram_writer;
  localparam int DW = 512;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] full_blocks = 32'd0;
  logic [7:0] partial = 8'd0;
  logic start = 1'b0;
  logic idle, bresp_error;
  logic [DW-1:0] tdata = '0;
  logic tvalid = 1'b0;
  logic tready;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [IW-1:0] awid;
  logic awlock, awvalid;
  logic [3:0] awcache, awqos;
  logic awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic wvalid, wlast;
  logic wready = 1'b0;
  logic [1:0] bresp = 2'd0;
  logic bvalid = 1'b0;
  logic bready;
  logic [63:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [IW-1:0] arid;
  logic arlock, arvalid, rready;
  logic [3:0] arcache, arqos;

  ram_writer #(.DW(DW), .IW(IW), .CYCLES_PER_BLOCK(64)) dut (
    .clk(clk), .resetn(resetn), .full_blocks(full_blocks), .partial_block_cycles(partial),
    .start(start), .idle(idle), .bresp_error(bresp_error),
    .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TREADY(tready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWID(awid), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWQOS(awqos),
    .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WLAST(wlast),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARID(arid), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(1'b0),
    .M_AXI_RDATA('0), .M_AXI_RRESP(2'd0), .M_AXI_RLAST(1'b0), .M_AXI_RID('0),
    .M_AXI_RVALID(1'b0), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model control (written by the initial block only)
  bit rnd = 1'b0;
  bit src_en = 1'b0;
  bit clr_req = 1'b0;
  int bad_b = -1;

  // Model state (written by the slave process only)
  int cyc = 0, aw_hs = 0, wl_hs = 0, b_sent = 0, beats = 0, activity = 0, src_idx = 0;
  bit consumed = 1'b0;
  logic [63:0] aw_addr_q[$];
  logic [7:0] aw_len_q[$];
  int aw_cyc_q[$];
  logic [DW-1:0] w_data_q[$];
  bit w_last_q[$];

  function automatic logic [DW-1:0] pat(input int i);
    return {16{32'(i) ^ 32'hA5A5_0000}};
  endfunction

  // Slave + stream source: drive on the falling edge, observe what the next rising edge accepts.
  always @(negedge clk) begin
    cyc++;
    if (clr_req) begin
      aw_hs = 0; wl_hs = 0; b_sent = 0; beats = 0; activity = 0; src_idx = 0;
      consumed = 1'b0; tvalid = 1'b0; bvalid = 1'b0;
      aw_addr_q.delete(); aw_len_q.delete(); aw_cyc_q.delete(); w_data_q.delete(); w_last_q.delete();
    end
    if (consumed) begin tvalid = 1'b0; consumed = 1'b0; end
    awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!tvalid) tvalid = src_en && (!rnd || ($urandom_range(0, 2) != 0));
    tdata  = pat(src_idx);
    bvalid = (((aw_hs < wl_hs) ? aw_hs : wl_hs) > b_sent) && (!rnd || ($urandom_range(0, 1) == 1));
    bresp  = (b_sent == bad_b) ? 2'd2 : 2'd0;
    #1;
    if (awvalid || wvalid) activity++;
    if (awvalid && awready) begin
      aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen); aw_cyc_q.push_back(cyc); aw_hs++;
    end
    if (wvalid && wready) begin
      w_data_q.push_back(wdata); w_last_q.push_back(wlast); beats++; src_idx++; consumed = 1'b1;
      if (wlast) wl_hs++;
    end
    if (bvalid) b_sent++;
  end

  task automatic clear_model();
    clr_req = 1'b1;
    @(negedge clk); #2;
    clr_req = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] fb, input logic [7:0] pb);
    @(negedge clk);
    full_blocks = fb; partial = pb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if ({awvalid, wvalid, wlast, tready, bresp_error} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {awvalid, wvalid, wlast, tready, bresp_error}); end
    checks++; if ({awaddr, awlen} !== 72'd0) begin errors++; $display("FAIL reset_aw: got %0h/%0h want 0/0", awaddr, awlen); end
    checks++; if ({awsize, awburst, bready, wstrb[0], arvalid, rready} !== {3'd6, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL consts: got size=%0d burst=%0d bready=%b strb=%b arvalid=%b rready=%b", awsize, awburst, bready, wstrb[0], arvalid, rready); end
    resetn = 1'b1;
  endtask

  task automatic test_full_bursts();
    bit ok;
    rnd = 1'b0; bad_b = -1; src_en = 1'b1;
    clear_model();
    do_start(32'd2, 8'd0);
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL first_awvalid: got %b want 1", awvalid); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_idle_timeout: got idle=%b want 1", idle); end
    checks++; if (aw_addr_q.size() !== 2) begin errors++; $display("FAIL full_aw_count: got %0d want 2", aw_addr_q.size()); end
    if (aw_addr_q.size() == 2) begin
      checks++; if (aw_addr_q[0] !== 64'h0 || aw_addr_q[1] !== 64'h1000) begin
        errors++; $display("FAIL full_aw_addr: got %0h,%0h want 0,1000", aw_addr_q[0], aw_addr_q[1]); end
      checks++; if (aw_len_q[0] !== 8'd63 || aw_len_q[1] !== 8'd63) begin
        errors++; $display("FAIL full_aw_len: got %0d,%0d want 63,63", aw_len_q[0], aw_len_q[1]); end
      checks++; if (aw_cyc_q[1] - aw_cyc_q[0] !== 1) begin
        errors++; $display("FAIL back_to_back_aw: got gap %0d want 1", aw_cyc_q[1] - aw_cyc_q[0]); end
    end
    checks++; if (beats !== 128) begin errors++; $display("FAIL full_beats: got %0d want 128", beats); end
    for (int i = 0; i < w_data_q.size(); i++) begin
      checks++; if (w_last_q[i] !== (i == 63 || i == 127)) begin
        errors++; $display("FAIL full_wlast[%0d]: got %b want %b", i, w_last_q[i], (i == 63 || i == 127)); end
      checks++; if (w_data_q[i] !== pat(i)) begin
        errors++; $display("FAIL full_data[%0d]: got %0h want %0h", i, w_data_q[i][31:0], pat(i) & 512'hFFFF_FFFF); end
    end
    checks++; if (b_sent !== 2) begin errors++; $display("FAIL full_bresp_count: got %0d want 2", b_sent); end
  endtask

  task automatic test_partial_only();
    bit ok;
    clear_model();
    do_start(32'd0, 8'd5);
    checks++; if (awvalid !== 1'b1 || awlen !== 8'd4 || awaddr !== 64'd0) begin
      errors++; $display("FAIL part_aw: got v=%b len=%0d addr=%0h want 1/4/0", awvalid, awlen, awaddr); end
    wait_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL part_idle_timeout: got idle=%b want 1", idle); end
    checks++; if (aw_hs !== 1 || beats !== 5 || b_sent !== 1) begin
      errors++; $display("FAIL part_counts: got aw=%0d beats=%0d b=%0d want 1/5/1", aw_hs, beats, b_sent); end
    if (w_last_q.size() == 5) begin
      checks++; if ({w_last_q[0], w_last_q[1], w_last_q[2], w_last_q[3], w_last_q[4]} !== 5'b00001) begin
        errors++; $display("FAIL part_wlast: got %b%b%b%b%b want 00001", w_last_q[0], w_last_q[1], w_last_q[2], w_last_q[3], w_last_q[4]); end
    end
  endtask

  task automatic test_zero_length();
    clear_model();
    do_start(32'd0, 8'd0);
    repeat (10) @(negedge clk);
    #2;
    checks++; if (activity !== 0) begin errors++; $display("FAIL zero_activity: got %0d cycles want 0", activity); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL zero_idle: got %b want 1", idle); end
  endtask

  task automatic test_random_stalls();
    bit ok;
    bit exp_last;
    logic [63:0] exp_addr [4];
    logic [7:0] exp_len [4];
    exp_addr = '{64'h0, 64'h1000, 64'h2000, 64'h3000};
    exp_len  = '{8'd63, 8'd63, 8'd63, 8'd9};
    rnd = 1'b1;
    clear_model();
    do_start(32'd3, 8'd10);
    wait_idle(5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_idle_timeout: got idle=%b want 1", idle); end
    checks++; if (b_sent !== 4) begin errors++; $display("FAIL rnd_idle_before_b: got b=%0d at idle want 4", b_sent); end
    checks++; if (aw_addr_q.size() !== 4) begin errors++; $display("FAIL rnd_aw_count: got %0d want 4", aw_addr_q.size()); end
    for (int i = 0; i < aw_addr_q.size() && i < 4; i++) begin
      checks++; if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== exp_len[i]) begin
        errors++; $display("FAIL rnd_aw[%0d]: got %0h/%0d want %0h/%0d", i, aw_addr_q[i], aw_len_q[i], exp_addr[i], exp_len[i]); end
    end
    checks++; if (beats !== 202) begin errors++; $display("FAIL rnd_beats: got %0d want 202", beats); end
    for (int i = 0; i < w_data_q.size(); i++) begin
      exp_last = (i == 63 || i == 127 || i == 191 || i == 201);
      checks++; if (w_last_q[i] !== exp_last || w_data_q[i] !== pat(i)) begin
        errors++; $display("FAIL rnd_beat[%0d]: got last=%b data=%0h want last=%b data=%0h",
                           i, w_last_q[i], w_data_q[i][31:0], exp_last, 32'(i) ^ 32'hA5A5_0000); end
    end
    rnd = 1'b0;
  endtask

  task automatic test_bresp_error();
    bit ok;
    bad_b = 1;
    clear_model();
    do_start(32'd2, 8'd7);
    checks++; if (bresp_error !== 1'b0) begin errors++; $display("FAIL berr_start: got %b want 0", bresp_error); end
    wait_idle(2000, ok);
    checks++; if (!ok || beats !== 135 || b_sent !== 3) begin
      errors++; $display("FAIL berr_xfer: got idle=%b beats=%0d b=%0d want 1/135/3", idle, beats, b_sent); end
    repeat (5) @(negedge clk);
    #2;
    checks++; if (bresp_error !== 1'b1) begin errors++; $display("FAIL berr_sticky: got %b want 1", bresp_error); end
    bad_b = -1;
    do_start(32'd0, 8'd0);
    checks++; if (bresp_error !== 1'b0) begin errors++; $display("FAIL berr_clear: got %b want 0", bresp_error); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clear_model();
    do_start(32'd2, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #2;
      if (beats >= 20) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_progress_timeout: got beats=%0d want >=20", beats); end
    src_en = 1'b0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    #2;
    checks++; if ({idle, awvalid, wvalid, wlast, tready, bresp_error} !== 6'b100000 || {awaddr, awlen} !== 72'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b aw=%0h/%0d want 100000 0/0",
                         {idle, awvalid, wvalid, wlast, tready, bresp_error}, awaddr, awlen); end
    src_en = 1'b1;
    clear_model();
    do_start(32'd0, 8'd5);
    wait_idle(500, ok);
    checks++; if (!ok || aw_hs !== 1 || beats !== 5 || b_sent !== 1) begin
      errors++; $display("FAIL mid_restart: got idle=%b aw=%0d beats=%0d b=%0d want 1/1/5/1", idle, aw_hs, beats, b_sent); end
    if (w_data_q.size() == 5) begin
      checks++; if (w_data_q[0] !== pat(0) || w_data_q[4] !== pat(4) || w_last_q[4] !== 1'b1) begin
        errors++; $display("FAIL mid_restart_data: got %0h/%0h last=%b want %0h/%0h last=1",
                           w_data_q[0][31:0], w_data_q[4][31:0], w_last_q[4], 32'hA5A5_0000, 32'hA5A5_0004); end
    end
  endtask

  initial begin
    test_reset();
    test_full_bursts();
    test_partial_only();
    test_zero_length();
    test_random_stalls();
    test_bresp_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
